glitch_window_ctrl: RTL and testbench
=====================================

# glitch_window_ctrl

Trigger-armed timing controller that decides when, and for how long, the glitched clock is substituted for the system clock. It synchronizes an external target trigger, waits a programmable delay, then asserts a glitch-enable window of programmable width, optionally repeated with a programmable gap. Its `glitch_en` output drives the `cnt` select input of the downstream `mux` stage, which ANDs it with `clk_c` and switches `glitched_clk` from `clk_in1` to `clk_b`.

## Interface
- `CNT_W`, 16: width of the delay, width and gap counters.
- `REP_W`, 8: width of the repeat counter.
- `clk_in1` in 1: single system clock; all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `arm` in 1: one-cycle pulse; honoured only in IDLE.
- `abort` in 1: level; forces return to IDLE.
- `trigger_in` in 1: asynchronous target trigger.
- `delay_cycles` in CNT_W: cycles from detected trigger to the first window.
- `width_cycles` in CNT_W: window length; 0 is treated as 1.
- `gap_cycles` in CNT_W: low time between windows; 0 is treated as 1.
- `repeat_cnt` in REP_W: number of windows; 0 is treated as 1.
- `glitch_en` out 1: registered window output, feeds `mux.cnt`.
- `armed` out 1: high in ARMED.
- `busy` out 1: high in DELAY, GLITCH or GAP.
- `done` out 1: one-cycle pulse after the last window ends.
- `glitch_idx` out REP_W: zero-based index of the current or last window.

## Operation
- FSM states: IDLE, ARMED, DELAY, GLITCH, GAP.
- **IDLE**: on `arm`, latch `delay_cycles`, `width_cycles`, `gap_cycles` and `repeat_cnt` into shadow registers, then go to ARMED. Live config inputs are ignored after this point.
- **ARMED**: on a synchronized rising edge of `trigger_in`, go to DELAY. If the shadowed delay is 0, go directly to GLITCH.
- **DELAY**: lasts exactly D cycles, then goes to GLITCH.
- **GLITCH**: `glitch_en`=1 for exactly W cycles. Then:
  - if windows remain, go to GAP;
  - otherwise pulse `done` and go to IDLE.
- **GAP**: `glitch_en`=0 for exactly G cycles, then go to GLITCH and increment `glitch_idx`.
- `arm` outside IDLE is ignored. Trigger edges outside ARMED are ignored; retriggering requires re-arm.
- `abort`, when high at an edge, forces the following:
  - next state is IDLE from any state;
  - `glitch_en` drops at that same edge;
  - no `done` pulse is issued;
  - `abort` has priority over `arm` and over the trigger.
- `glitch_en` is a flop output with no combinational path from inputs, so it is glitch-free.
- Counters are down-counters of CNT_W bits loaded with N-1, so the maximum count is 2^CNT_W-1 with no wrap-around.
- Reset values:
  - state IDLE;
  - `glitch_en`, `armed`, `busy`, `done` = 0;
  - `glitch_idx` = 0;
  - synchronizer flops = 0.
- Reset is async and mid-window: `glitch_en` drops immediately on assertion of `resetn`=0.

## Timing
- E0 is the first `clk_in1` edge that samples `trigger_in` high. E0 is the 2-flop synchronizer input stage.
- Edge detect is valid after E1. The FSM leaves ARMED at E2.
- `glitch_en` rises at edge E0+2+D and falls at E0+2+D+W.
- With repeats, window k rises at E0+2+D+k·(W+G).
- `done` is high in the cycle after the final falling edge of `glitch_en`, i.e. registered at E0+2+D+R·W+(R-1)·G.
- `arm` to `armed`: 1 cycle.
- `abort` to `glitch_en`=0: 1 edge.
- A `trigger_in` pulse must be at least 2 `clk_in1` periods wide to be guaranteed detection.

## Structure
- Shared package `glitch_pkg`:
  - `gw_state_t` enum;
  - default `CNT_W`/`REP_W` localparams;
  - config struct `gw_cfg_t` {delay, width, gap, repeat}, reused by the future register/UART front end.
- One sub-module, `sync_edge_det`: 2-flop synchronizer, third flop, and rising-edge pulse output. It takes the same async active-low reset.
- The FSM and counters live in `glitch_window_ctrl`.

## Test plan
- **Single window:** D=5, W=3, R=1, trigger rising at E0 → `glitch_en` high during edges E0+7 to E0+10, `done` at E0+10, `glitch_idx`=0.
- **Zero config:** D=0, W=0, R=0 → DELAY is skipped; exactly one 1-cycle window at E0+2; `done` follows.
- **Repeats:** D=2, W=2, G=4, R=3 → three windows starting at E0+4, E0+10, E0+16; `glitch_idx` steps 0→1→2; a single `done`.
- **Abort mid-GLITCH** (W=10, abort after 4 cycles) → `glitch_en` low at the next edge, state IDLE, no `done`. Re-arm and retrigger then works normally.
- **Ignored events:**
  - second trigger during DELAY → timing unchanged;
  - config inputs changed after arm → shadow values still used;
  - `arm` while busy → no effect.
- **Reset and short trigger:**
  - `resetn` asserted during a window → `glitch_en`=0 asynchronously, and all outputs hold reset values;
  - 1-cycle `trigger_in` pulse aligned away from an edge → no detection, `armed` stays high.

Source files
------------

// File: rtl/glitch_pkg.sv
// ----------------------------------------------------------------------------
// glitch_pkg : shared state and configuration types for glitch_window_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package glitch_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_REP_W = 8;

    typedef enum logic [2:0] {
        GW_IDLE   = 3'd0,
        GW_ARMED  = 3'd1,
        GW_DELAY  = 3'd2,
        GW_GLITCH = 3'd3,
        GW_GAP    = 3'd4
    } gw_state_t;

    // Window configuration as captured on arm; also the register-map layout
    typedef struct packed {
        logic [DEF_CNT_W-1:0] delay;
        logic [DEF_CNT_W-1:0] width;
        logic [DEF_CNT_W-1:0] gap;
        logic [DEF_REP_W-1:0] repeats;
    } gw_cfg_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det : 2-flop synchronizer plus history flop, rising-edge pulse
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], din};
        end
    end

    // r_sync[0] may be metastable; only the settled stages feed the detector
    assign rise = r_sync[1] & ~r_sync[2];

endmodule

`default_nettype wire

// File: rtl/glitch_window_ctrl.sv
// ----------------------------------------------------------------------------
// glitch_window_ctrl : trigger-armed delay / window / gap timing for glitch_en
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module glitch_window_ctrl
    import glitch_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk_in1,
    input  logic             resetn,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger_in,
    input  logic [CNT_W-1:0] delay_cycles,
    input  logic [CNT_W-1:0] width_cycles,
    input  logic [CNT_W-1:0] gap_cycles,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             glitch_en,
    output logic             armed,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] glitch_idx
);

    gw_state_t        r_state;
    gw_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [REP_W-1:0] r_idx;
    logic [REP_W-1:0] w_idx_nxt;
    logic             r_glitch_en;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_load_cfg;
    logic             w_trig_rise;

    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_gap;
    logic [REP_W-1:0] r_rep;

    logic [CNT_W-1:0] w_width_ld;
    logic [CNT_W-1:0] w_gap_ld;
    logic             w_last_window;

    sync_edge_det u_sync (
        .clk   (clk_in1),
        .rst_n (resetn),
        .din   (trigger_in),
        .rise  (w_trig_rise)
    );

    // Counters hold N-1 so a zero width/gap degenerates to a single cycle
    assign w_width_ld    = (r_width == '0) ? '0 : r_width - 1'b1;
    assign w_gap_ld      = (r_gap   == '0) ? '0 : r_gap   - 1'b1;
    assign w_last_window = (r_rep == '0) || (r_idx == r_rep - 1'b1);

    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            r_delay <= '0;
            r_width <= '0;
            r_gap   <= '0;
            r_rep   <= '0;
        end else if (w_load_cfg) begin
            r_delay <= delay_cycles;
            r_width <= width_cycles;
            r_gap   <= gap_cycles;
            r_rep   <= repeat_cnt;
        end
    end

    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= GW_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_glitch_en <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_glitch_en <= (w_state_nxt == GW_GLITCH);
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_load_cfg  = 1'b0;

        if (abort) begin
            w_state_nxt = GW_IDLE;
        end else begin
            case (r_state)
                GW_IDLE: begin
                    if (arm) begin
                        w_load_cfg  = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = GW_ARMED;
                    end
                end
                GW_ARMED: begin
                    if (w_trig_rise) begin
                        if (r_delay == '0) begin
                            w_state_nxt = GW_GLITCH;
                            w_cnt_nxt   = w_width_ld;
                        end else begin
                            w_state_nxt = GW_DELAY;
                            w_cnt_nxt   = r_delay - 1'b1;
                        end
                    end
                end
                GW_DELAY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = GW_GLITCH;
                        w_cnt_nxt   = w_width_ld;
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                GW_GLITCH: begin
                    if (r_cnt == '0) begin
                        if (w_last_window) begin
                            w_state_nxt = GW_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = GW_GAP;
                            w_cnt_nxt   = w_gap_ld;
                        end
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                GW_GAP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = GW_GLITCH;
                        w_cnt_nxt   = w_width_ld;
                        w_idx_nxt   = r_idx + 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = GW_IDLE;
                end
            endcase
        end
    end

    assign glitch_en  = r_glitch_en;
    assign done       = r_done;
    assign glitch_idx = r_idx;
    assign armed      = (r_state == GW_ARMED);
    assign busy       = (r_state == GW_DELAY) || (r_state == GW_GLITCH) || (r_state == GW_GAP);

endmodule

`default_nettype wire

// File: tb/tb_glitch_window_ctrl.sv
// ----------------------------------------------------------------------------
// tb_glitch_window_ctrl : schedule-model checker plus directed literal checks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_glitch_window_ctrl;

    logic        clk_in1 = 1'b0;
    logic        resetn;
    logic        arm;
    logic        abort;
    logic        trigger_in;
    logic [15:0] delay_cycles;
    logic [15:0] width_cycles;
    logic [15:0] gap_cycles;
    logic [7:0]  repeat_cnt;
    logic        glitch_en;
    logic        armed;
    logic        busy;
    logic        done;
    logic [7:0]  glitch_idx;

    int n_checks = 0;
    int n_pass   = 0;

    glitch_window_ctrl #(.CNT_W(16), .REP_W(8)) dut (
        .clk_in1      (clk_in1),
        .resetn       (resetn),
        .arm          (arm),
        .abort        (abort),
        .trigger_in   (trigger_in),
        .delay_cycles (delay_cycles),
        .width_cycles (width_cycles),
        .gap_cycles   (gap_cycles),
        .repeat_cnt   (repeat_cnt),
        .glitch_en    (glitch_en),
        .armed        (armed),
        .busy         (busy),
        .done         (done),
        .glitch_idx   (glitch_idx)
    );

    always #5 clk_in1 = ~clk_in1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Schedule model: once a trigger edge is accepted, every output is a
    // function of the edge offset from the start and the captured config.
    int n_edge = 0;
    bit m_armed, m_run, m_done, m_ge, m_prev_trig, m_pend_v;
    int m_pend_e0, m_start, m_end, m_d, m_w, m_g, m_r, m_idx;

    task automatic model_step();
        bit rise_now;
        int rel;
        int per;
        m_done = 1'b0;
        if (!resetn) begin
            m_armed = 0; m_run = 0; m_idx = 0; m_ge = 0;
            m_prev_trig = 0; m_pend_v = 0;
            return;
        end
        rise_now = m_pend_v && (n_edge == m_pend_e0 + 2);
        if (abort) begin
            m_armed = 0;
            m_run   = 0;
        end else if (m_run) begin
            if (n_edge == m_end) begin
                m_run  = 0;
                m_done = 1;
            end
        end else if (m_armed) begin
            if (rise_now) begin
                m_armed = 0;
                m_run   = 1;
                m_start = n_edge;
                m_end   = m_start + m_d + m_r * m_w + (m_r - 1) * m_g;
            end
        end else if (arm) begin
            m_armed = 1;
            m_idx   = 0;
            m_d     = int'(delay_cycles);
            m_w     = (width_cycles == 16'd0) ? 1 : int'(width_cycles);
            m_g     = (gap_cycles   == 16'd0) ? 1 : int'(gap_cycles);
            m_r     = (repeat_cnt   == 8'd0)  ? 1 : int'(repeat_cnt);
        end
        m_ge = 0;
        if (m_run) begin
            rel = n_edge - m_start;
            per = m_w + m_g;
            if (rel >= m_d) begin
                m_idx = (rel - m_d) / per;
                if (m_idx > m_r - 1) m_idx = m_r - 1;
                m_ge = (((rel - m_d) % per) < m_w);
            end
        end
        if (trigger_in && !m_prev_trig) begin
            m_pend_v  = 1;
            m_pend_e0 = n_edge;
        end
        m_prev_trig = trigger_in;
    endtask

    initial begin
        forever begin
            @(posedge clk_in1);
            n_edge++;
            model_step();
            #1;
            chk("cyc_glitch_en", 32'(glitch_en), 32'(m_ge));
            chk("cyc_done",      32'(done),      32'(m_done));
            chk("cyc_armed",     32'(armed),     32'(m_armed));
            chk("cyc_busy",      32'(busy),      32'(m_run));
            chk("cyc_idx",       32'(glitch_idx), m_idx);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    task automatic pw(input int k);
        repeat (k) @(posedge clk_in1);
        #2;
    endtask

    task automatic do_arm(input int d, input int w, input int g, input int r);
        @(negedge clk_in1);
        delay_cycles = 16'(d);
        width_cycles = 16'(w);
        gap_cycles   = 16'(g);
        repeat_cnt   = 8'(r);
        arm = 1'b1;
        @(negedge clk_in1);
        arm = 1'b0;
        chk("arm_to_armed", 32'(armed), 32'd1);
    endtask

    // Leaves the bench 2 time units after E0
    task automatic fire();
        @(negedge clk_in1);
        trigger_in = 1'b1;
        @(posedge clk_in1);
        #2;
    endtask

    initial begin
        resetn = 1'b0; arm = 1'b0; abort = 1'b0; trigger_in = 1'b0;
        delay_cycles = '0; width_cycles = '0; gap_cycles = '0; repeat_cnt = '0;
        pw(1);
        chk("rst_glitch_en", 32'(glitch_en), 32'd0);
        chk("rst_armed",     32'(armed),     32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_idx",       32'(glitch_idx), 32'd0);
        @(negedge clk_in1);
        resetn = 1'b1;

        // Single window D=5 W=3 R=1
        do_arm(5, 3, 0, 1);
        fire();
        pw(6); chk("single_pre", 32'(glitch_en), 32'd0);
        trigger_in = 1'b0;
        pw(1); chk("single_rise", 32'(glitch_en), 32'd1);
               chk("single_busy", 32'(busy), 32'd1);
        pw(2); chk("single_hold", 32'(glitch_en), 32'd1);
        pw(1); chk("single_fall", 32'(glitch_en), 32'd0);
               chk("single_done", 32'(done), 32'd1);
               chk("single_idx",  32'(glitch_idx), 32'd0);
        pw(1); chk("single_done_pulse", 32'(done), 32'd0);
        pw(2);

        // Zero config: delay skipped, one 1-cycle window
        do_arm(0, 0, 0, 0);
        fire();
        pw(1); chk("zero_e1", 32'(glitch_en), 32'd0);
        pw(1); chk("zero_e2", 32'(glitch_en), 32'd1);
        trigger_in = 1'b0;
        pw(1); chk("zero_e3_ge",   32'(glitch_en), 32'd0);
               chk("zero_e3_done", 32'(done), 32'd1);
        pw(2);

        // Repeats D=2 W=2 G=4 R=3
        do_arm(2, 2, 4, 3);
        fire();
        pw(2); trigger_in = 1'b0;
        pw(2); chk("rep_w0",  32'(glitch_en), 32'd1);
               chk("rep_i0",  32'(glitch_idx), 32'd0);
        pw(2); chk("rep_gap", 32'(glitch_en), 32'd0);
               chk("rep_gap_done", 32'(done), 32'd0);
        pw(4); chk("rep_w1",  32'(glitch_en), 32'd1);
               chk("rep_i1",  32'(glitch_idx), 32'd1);
        pw(6); chk("rep_w2",  32'(glitch_en), 32'd1);
               chk("rep_i2",  32'(glitch_idx), 32'd2);
        pw(2); chk("rep_end", 32'(glitch_en), 32'd0);
               chk("rep_done", 32'(done), 32'd1);
        pw(1); chk("rep_idx_hold", 32'(glitch_idx), 32'd2);
        pw(2);

        // Ignored events: config change after arm, retrigger and arm in DELAY
        do_arm(6, 2, 0, 1);
        @(negedge clk_in1);
        delay_cycles = 16'd1; width_cycles = 16'd9; gap_cycles = 16'd9; repeat_cnt = 8'd9;
        fire();
        pw(1); trigger_in = 1'b0;
        pw(2); trigger_in = 1'b1;
        pw(2); arm = 1'b1;
        pw(1); arm = 1'b0;
               chk("ign_busy",  32'(busy),  32'd1);
               chk("ign_armed", 32'(armed), 32'd0);
        pw(1); chk("ign_pre", 32'(glitch_en), 32'd0);
        trigger_in = 1'b0;
        pw(1); chk("ign_rise", 32'(glitch_en), 32'd1);
        pw(2); chk("ign_fall", 32'(glitch_en), 32'd0);
               chk("ign_done", 32'(done), 32'd1);
        pw(1); chk("ign_idle", 32'(armed), 32'd0);
        pw(2);

        // Abort mid-window, abort beats arm, then normal re-arm
        do_arm(1, 10, 1, 1);
        fire();
        pw(2); trigger_in = 1'b0;
        pw(1); chk("abt_rise", 32'(glitch_en), 32'd1);
        pw(3); chk("abt_mid",  32'(glitch_en), 32'd1);
        abort = 1'b1;
        pw(1); chk("abt_ge",   32'(glitch_en), 32'd0);
               chk("abt_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        pw(6); chk("abt_no_done", 32'(done), 32'd0);
        @(negedge clk_in1); arm = 1'b1; abort = 1'b1;
        @(negedge clk_in1); arm = 1'b0; abort = 1'b0;
        chk("abt_over_arm", 32'(armed), 32'd0);
        do_arm(1, 1, 1, 1);
        fire();
        pw(3); chk("rearm_rise", 32'(glitch_en), 32'd1);
        trigger_in = 1'b0;
        pw(1); chk("rearm_done", 32'(done), 32'd1);
        pw(2);

        // Asynchronous reset in the middle of the third window
        do_arm(0, 1, 1, 3);
        fire();
        pw(2); chk("rst_w0", 32'(glitch_en), 32'd1);
        trigger_in = 1'b0;
        pw(4); chk("rst_w2", 32'(glitch_en), 32'd1);
               chk("rst_i2", 32'(glitch_idx), 32'd2);
        #1 resetn = 1'b0;
        #1;
        chk("arst_ge",    32'(glitch_en), 32'd0);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_armed", 32'(armed), 32'd0);
        chk("arst_done",  32'(done), 32'd0);
        chk("arst_idx",   32'(glitch_idx), 32'd0);
        repeat (2) @(negedge clk_in1);
        resetn = 1'b1;
        pw(2);

        // Sub-period trigger pulse between edges is not detected
        do_arm(3, 1, 1, 1);
        @(posedge clk_in1);
        #2 trigger_in = 1'b1;
        #6 trigger_in = 1'b0;
        pw(4); chk("short_armed", 32'(armed), 32'd1);
               chk("short_busy",  32'(busy), 32'd0);
        @(negedge clk_in1); abort = 1'b1;
        @(negedge clk_in1); abort = 1'b0;
        chk("short_abort", 32'(armed), 32'd0);
        pw(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
